// File: rtl/data_cache_controller_if.sv
// CPU-side request/response and main-memory block transfer signals
// of the MEM-stage data cache, bundled for connection as one port.
interface data_cache_controller_if;
   logic         READ;
   logic         WRITE;
   logic [2:0]   FUNCT3;
   logic [31:0]  ADDRESS;
   logic [31:0]  WRITE_DATA;
   logic [31:0]  DATA_OUT;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic         MEM_WRITE;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_WRITEDATA;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   modport slave (
      input  READ, WRITE, FUNCT3, ADDRESS, WRITE_DATA,
      input  MEM_READDATA, MEM_BUSYWAIT,
      output DATA_OUT, BUSYWAIT,
      output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );

   modport master (
      output READ, WRITE, FUNCT3, ADDRESS, WRITE_DATA,
      output MEM_READDATA, MEM_BUSYWAIT,
      input  DATA_OUT, BUSYWAIT,
      input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );
endinterface

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Loads hit combinationally; misses evict/refill 128-bit blocks.
module data_cache_controller #(
   parameter int INDEX_BITS  = 3,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   data_cache_controller_if.slave bus
);
   localparam int LINES      = 1 << INDEX_BITS;
   localparam int TAG_W      = 28 - INDEX_BITS;
   localparam int BLOCK_BITS = 32 * BLOCK_WORDS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WB,
      S_FETCH,
      S_UPDATE
   } state_t;

   state_t state_q, state_d;

   logic [LINES-1:0]      valid_q;
   logic [LINES-1:0]      dirty_q;
   logic [TAG_W-1:0]      tag_q  [LINES];
   logic [BLOCK_BITS-1:0] data_q [LINES];
   logic [BLOCK_BITS-1:0] fill_q;

   logic [TAG_W-1:0]      req_tag;
   logic [INDEX_BITS-1:0] idx;
   logic [1:0]            wsel;
   logic [1:0]            bsel;
   logic [TAG_W-1:0]      line_tag;
   logic [BLOCK_BITS-1:0] line_data;
   logic                  hit;
   logic                  req;
   logic                  is_rd;
   logic                  is_wr;

   assign req_tag   = bus.ADDRESS[31:4+INDEX_BITS];
   assign idx       = bus.ADDRESS[3+INDEX_BITS:4];
   assign wsel      = bus.ADDRESS[3:2];
   assign bsel      = bus.ADDRESS[1:0];
   assign line_tag  = tag_q[idx];
   assign line_data = data_q[idx];
   assign hit       = valid_q[idx] && (line_tag == req_tag);
   assign req       = bus.READ | bus.WRITE;
   assign is_wr     = bus.WRITE;
   assign is_rd     = bus.READ & ~bus.WRITE;

   logic [31:0]           word;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [31:0]           ld_val;
   logic [31:0]           merged;
   logic [BLOCK_BITS-1:0] new_line;

   assign word = line_data[32*wsel +: 32];

   always_comb begin
      byte_v = word[8*bsel +: 8];
      half_v = word[16*bsel[1] +: 16];
      case (bus.FUNCT3)
         3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
         3'b001:  ld_val = {{16{half_v[15]}}, half_v};
         3'b100:  ld_val = {24'b0, byte_v};
         3'b101:  ld_val = {16'b0, half_v};
         default: ld_val = word;
      endcase
   end

   always_comb begin
      merged = word;
      case (bus.FUNCT3[1:0])
         2'b00:   merged[8*bsel +: 8] = bus.WRITE_DATA[7:0];
         2'b01:   merged[16*bsel[1] +: 16] = bus.WRITE_DATA[15:0];
         default: merged = bus.WRITE_DATA;
      endcase
      new_line = line_data;
      new_line[32*wsel +: 32] = merged;
   end

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req && !hit)
               state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FETCH;
         end
         S_WB:     if (!bus.MEM_BUSYWAIT) state_d = S_FETCH;
         S_FETCH:  if (!bus.MEM_BUSYWAIT) state_d = S_UPDATE;
         S_UPDATE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   logic                  mem_rd;
   logic                  mem_wr;
   logic [27:0]           mem_addr;
   logic [BLOCK_BITS-1:0] mem_wdata;
   logic                  busy;
   logic [31:0]           dout;

   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
      dout      = '0;
      case (state_q)
         S_IDLE: begin
            busy = req & ~hit;
            if (is_rd && hit) dout = ld_val;
         end
         S_WB: begin
            mem_wr    = 1'b1;
            mem_addr  = {line_tag, idx};
            mem_wdata = line_data;
            busy      = 1'b1;
         end
         S_FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = {req_tag, idx};
            busy     = 1'b1;
         end
         default: busy = 1'b1;
      endcase
      // Stall and load data are forced quiet for the whole reset cycle
      if (RESET) begin
         busy = 1'b0;
         dout = '0;
      end
   end

   assign bus.MEM_READ      = mem_rd;
   assign bus.MEM_WRITE     = mem_wr;
   assign bus.MEM_ADDRESS   = mem_addr;
   assign bus.MEM_WRITEDATA = mem_wdata;
   assign bus.BUSYWAIT      = busy;
   assign bus.DATA_OUT      = dout;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (state_q == S_IDLE && is_wr && hit) begin
            data_q[idx]  <= new_line;
            dirty_q[idx] <= 1'b1;
         end
         if (state_q == S_FETCH && !bus.MEM_BUSYWAIT)
            fill_q <= bus.MEM_READDATA;
         if (state_q == S_UPDATE) begin
            data_q[idx]  <= fill_q;
            tag_q[idx]   <= req_tag;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
      end
   end
endmodule
